// File: rtl/neosd_card_cmd_fsm.sv
// Card-side SD CMD line engine: receives 48-bit host commands and returns
// short/long responses after the NCR gap, all timed off a synchronised sd_clk.
module neosd_card_cmd_fsm #(
   parameter int NCR = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         sd_clk_i,
   input  logic         sd_cmd_i,
   output logic         sd_cmd_o,
   output logic         sd_cmd_oe,
   output logic         cmd_valid_o,
   output logic [5:0]   cmd_idx_o,
   output logic [31:0]  cmd_arg_o,
   output logic         cmd_crc_err_o,
   output logic         cmd_frame_err_o,
   input  logic         resp_start_i,
   input  logic [1:0]   resp_mode_i,
   input  logic [5:0]   resp_idx_i,
   input  logic [31:0]  resp_arg_i,
   input  logic [127:0] resp_long_i,
   output logic         busy_o
);

   typedef enum logic [2:0] {S_IDLE, S_RX, S_CMD_OUT, S_WAIT_NCR, S_TX, S_RELEASE} state_t;

   localparam logic [7:0] NCR_C = 8'(NCR);

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
      return c;
   endfunction

   state_t         state, state_d;
   logic [1:0]     clk_sync, cmd_sync;
   logic           clk_prev, rise, fall, cmd_bit;
   logic [7:0]     bit_cnt, ncr_cnt, tx_cnt, tx_len;
   logic [46:0]    rx_sr;
   logic [47:0]    rx_frame;
   logic [6:0]     crc;
   logic [135:0]   tx_sr;
   logic [39:0]    short_body;
   logic [47:0]    short_frame;
   logic [135:0]   long_frame;
   logic           ncr_done;
   logic           unused_long_lsb;

   assign unused_long_lsb = resp_long_i[0];

   // Reset the CMD synchroniser to idle-high so a reset never fakes a start bit
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_sync <= 2'b00;
         cmd_sync <= 2'b11;
         clk_prev <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], sd_clk_i};
         cmd_sync <= {cmd_sync[0], sd_cmd_i};
         clk_prev <= clk_sync[1];
      end
   end

   assign rise    = clk_sync[1] & ~clk_prev;
   assign fall    = ~clk_sync[1] & clk_prev;
   assign cmd_bit = cmd_sync[1];

   assign rx_frame    = {rx_sr, cmd_bit};
   assign short_body  = {2'b00, resp_idx_i, resp_arg_i};
   assign short_frame = {short_body, crc7_40(short_body), 1'b1};
   assign long_frame  = {2'b00, 6'b111111, resp_long_i[127:1], 1'b1};
   assign ncr_done    = (ncr_cnt >= NCR_C - 8'd1);
   assign busy_o      = (state != S_IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:     if (rise && !cmd_bit) state_d = S_RX;
         S_RX:       if (rise && bit_cnt == 8'd47) state_d = S_CMD_OUT;
         S_CMD_OUT:  if (resp_start_i)
                        state_d = (resp_mode_i == 2'd1 || resp_mode_i == 2'd2) ? S_WAIT_NCR : S_IDLE;
         S_WAIT_NCR: if (fall && ncr_done) state_d = S_TX;
         S_TX:       if (fall && tx_cnt == tx_len - 8'd1) state_d = S_RELEASE;
         S_RELEASE:  if (fall) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sd_cmd_o        <= 1'b1;
         sd_cmd_oe       <= 1'b0;
         cmd_valid_o     <= 1'b0;
         cmd_idx_o       <= '0;
         cmd_arg_o       <= '0;
         cmd_crc_err_o   <= 1'b0;
         cmd_frame_err_o <= 1'b0;
         bit_cnt         <= '0;
         ncr_cnt         <= '0;
         tx_cnt          <= '0;
         tx_len          <= '0;
         rx_sr           <= '0;
         crc             <= '0;
         tx_sr           <= '0;
      end else begin
         case (state)
            S_IDLE: if (rise && !cmd_bit) begin
               bit_cnt <= 8'd1;
               rx_sr   <= '0;
               crc     <= '0;
            end
            S_RX: if (rise) begin
               rx_sr   <= {rx_sr[45:0], cmd_bit};
               bit_cnt <= bit_cnt + 8'd1;
               // CRC covers frame bits 47..8, i.e. bit counts 0..39
               if (bit_cnt <= 8'd39) crc <= crc7_step(crc, cmd_bit);
               if (bit_cnt == 8'd47) begin
                  cmd_idx_o       <= rx_frame[45:40];
                  cmd_arg_o       <= rx_frame[39:8];
                  cmd_crc_err_o   <= (rx_frame[7:1] != crc);
                  cmd_frame_err_o <= !rx_frame[46] || !rx_frame[0];
                  cmd_valid_o     <= 1'b1;
                  ncr_cnt         <= '0;
               end
            end
            S_CMD_OUT: begin
               if (fall && ncr_cnt < NCR_C) ncr_cnt <= ncr_cnt + 8'd1;
               if (resp_start_i) begin
                  cmd_valid_o <= 1'b0;
                  if (resp_mode_i == 2'd1) begin
                     tx_sr  <= {short_frame, 88'd0};
                     tx_len <= 8'd48;
                  end else if (resp_mode_i == 2'd2) begin
                     tx_sr  <= long_frame;
                     tx_len <= 8'd136;
                  end
               end
            end
            S_WAIT_NCR: if (fall) begin
               if (ncr_done) begin
                  sd_cmd_oe <= 1'b1;
                  sd_cmd_o  <= tx_sr[135];
                  tx_sr     <= {tx_sr[134:0], 1'b0};
                  tx_cnt    <= 8'd1;
               end else begin
                  ncr_cnt <= ncr_cnt + 8'd1;
               end
            end
            S_TX: if (fall) begin
               sd_cmd_o <= tx_sr[135];
               tx_sr    <= {tx_sr[134:0], 1'b0};
               tx_cnt   <= tx_cnt + 8'd1;
            end
            S_RELEASE: if (fall) begin
               sd_cmd_oe <= 1'b0;
               sd_cmd_o  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
